idli_sqi_fetch_m: RTL and testbench

Instruction fetch front end for the SQI (quad-SPI) serial memory. It drives the memory command/address sequence, assembles the returning nibble stream into 16b encodings and owns the free-running 2b sync counter that phases every 4-GCK period. It feeds the decoder, which flops `o_sq_enc` when `o_sq_ctr` is 3 and `o_sq_enc_vld` is high. It also accepts PC redirects from execute and restarts the sequential read at the new address.

---
 rtl/idli_sqi_fetch_m_if.sv | 27 ++
 rtl/idli_sqi_fetch_m.sv | 151 +++++++++++++++
 tb/tb_idli_sqi_fetch_m.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/idli_sqi_fetch_m_if.sv
// SQI fetch bundle: execute redirect, SQI pins and decoder-facing encoding stream.
// master = fetch block, slave = memory/decoder/execute side.
interface idli_sqi_fetch_m_if;
  logic        i_sq_redir;
  logic [15:0] i_sq_redir_pc;
  logic        o_sq_cs_n;
  logic        o_sq_sio_oe;
  logic [3:0]  o_sq_sio;
  logic [3:0]  i_sq_sio;
  logic [1:0]  o_sq_ctr;
  logic [15:0] o_sq_enc;
  logic        o_sq_enc_vld;
  logic [15:0] o_sq_pc;
  logic [15:0] o_sq_fetch_cnt;

  modport master (
    input  i_sq_redir, i_sq_redir_pc, i_sq_sio,
    output o_sq_cs_n, o_sq_sio_oe, o_sq_sio, o_sq_ctr,
           o_sq_enc, o_sq_enc_vld, o_sq_pc, o_sq_fetch_cnt
  );

  modport slave (
    output i_sq_redir, i_sq_redir_pc, i_sq_sio,
    input  o_sq_cs_n, o_sq_sio_oe, o_sq_sio, o_sq_ctr,
           o_sq_enc, o_sq_enc_vld, o_sq_pc, o_sq_fetch_cnt
  );
endinterface

// File: rtl/idli_sqi_fetch_m.sv
// SQI instruction fetch: READ 0x03 sequencer, nibble assembly, sync counter, PC redirect.
// Optional delivered-instruction counter enabled by IDLI_SQI_FETCH_CNT_EN.
module idli_sqi_fetch_m (
  input  logic                   i_sq_gck,
  input  logic                   i_sq_rst_n,
  idli_sqi_fetch_m_if.master     sq
);
  typedef logic [15:0] data_t;
  typedef logic [1:0]  ctr_t;
  typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA} st_t;

  st_t         st_q, st_d;
  logic [2:0]  cnt_q, cnt_d;
  ctr_t        ctr_q, ctr_d;
  logic        pend_q, pend_d;
  data_t       pc_q, pc_d;
  logic [11:0] buf_q, buf_d;
  logic [23:0] addr;
  logic        enc_vld;
  logic [3:0]  sio;

  always_ff @(posedge i_sq_gck or negedge i_sq_rst_n) begin
    if (!i_sq_rst_n) begin
      st_q   <= ST_IDLE;
      cnt_q  <= '0;
      ctr_q  <= '0;
      pend_q <= 1'b1;
      pc_q   <= '0;
      buf_q  <= '0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      ctr_q  <= ctr_d;
      pend_q <= pend_d;
      pc_q   <= pc_d;
      buf_q  <= buf_d;
    end
  end

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    ctr_d   = ctr_q + 2'd1;
    pend_d  = pend_q;
    pc_d    = pc_q;
    buf_d   = buf_q;
    enc_vld = 1'b0;
    case (st_q)
      ST_IDLE: begin
        if (ctr_q == 2'd1 && pend_q) begin
          st_d   = ST_CMD;
          cnt_d  = '0;
          pend_d = 1'b0;
        end
      end
      ST_CMD: begin
        if (cnt_q == 3'd1) begin
          st_d  = ST_ADDR;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_ADDR: begin
        if (cnt_q == 3'd5) begin
          st_d  = ST_DUMMY;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_DUMMY: begin
        if (cnt_q == 3'd1) begin
          st_d  = ST_DATA;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_DATA: begin
        case (ctr_q)
          2'd0: buf_d[3:0]  = sq.i_sq_sio;
          2'd1: buf_d[7:4]  = sq.i_sq_sio;
          2'd2: buf_d[11:8] = sq.i_sq_sio;
          default: begin
            enc_vld = !sq.i_sq_redir;
            // Sequential reads cannot cross the 16b word space; force a fresh READ at 0.
            if (pc_q == 16'hFFFF) begin
              pend_d = 1'b1;
              pc_d   = '0;
              st_d   = ST_IDLE;
            end else begin
              pc_d = pc_q + 16'd1;
            end
          end
        endcase
      end
      default: st_d = ST_IDLE;
    endcase
    // Redirect overrides every other transition, including IDLE->CMD in the same cycle.
    if (sq.i_sq_redir) begin
      pend_d = 1'b1;
      pc_d   = sq.i_sq_redir_pc;
      st_d   = ST_IDLE;
      cnt_d  = '0;
    end
  end

  assign addr = {7'b0, pc_q, 1'b0};

  always_comb begin
    sio = '0;
    case (st_q)
      ST_CMD:  sio = (cnt_q == 3'd0) ? 4'h0 : 4'h3;
      ST_ADDR: begin
        case (cnt_q)
          3'd0:    sio = addr[23:20];
          3'd1:    sio = addr[19:16];
          3'd2:    sio = addr[15:12];
          3'd3:    sio = addr[11:8];
          3'd4:    sio = addr[7:4];
          default: sio = addr[3:0];
        endcase
      end
      default: sio = '0;
    endcase
  end

  assign sq.o_sq_cs_n    = (st_q == ST_IDLE);
  assign sq.o_sq_sio_oe  = (st_q == ST_CMD) || (st_q == ST_ADDR);
  assign sq.o_sq_sio     = sio;
  assign sq.o_sq_ctr     = ctr_q;
  assign sq.o_sq_enc     = {sq.i_sq_sio, buf_q};
  assign sq.o_sq_enc_vld = enc_vld;
  assign sq.o_sq_pc      = pc_q;

`ifdef IDLI_SQI_FETCH_CNT_EN
  data_t fcnt_q, fcnt_d;

  always_comb fcnt_d = fcnt_q + (enc_vld ? 16'd1 : 16'd0);

  always_ff @(posedge i_sq_gck or negedge i_sq_rst_n) begin
    if (!i_sq_rst_n) fcnt_q <= '0;
    else             fcnt_q <= fcnt_d;
  end

  assign sq.o_sq_fetch_cnt = fcnt_q;
`else
  assign sq.o_sq_fetch_cnt = '0;
`endif
endmodule

// File: tb/tb_idli_sqi_fetch_m.sv
// Bench for idli_sqi_fetch_m: SQI memory model plus transaction-level fetch model.
module tb_idli_sqi_fetch_m;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  idli_sqi_fetch_m_if sq ();
  idli_sqi_fetch_m dut (.i_sq_gck(clk), .i_sq_rst_n(rst_n), .sq(sq));

  int tests = 0;
  int fails = 0;
  int cyc;

  logic [15:0] mem [65536];

  // transaction-level model state
  bit          m_busy, m_pend;
  logic [15:0] exp_pc;
  logic [1:0]  mctr;
  int          m_cyc;
  logic [31:0] sh;
  logic [15:0] m_waddr;
  logic [15:0] fcnt;
  logic [23:0] last_addr;

  // per-cycle samples
  logic        s_cs_n, s_oe, s_vld;
  logic [3:0]  s_sio;
  logic [1:0]  s_ctr;
  logic [15:0] s_enc, s_pc, s_fcnt;

  task automatic model_reset();
    m_busy = 1'b0; m_pend = 1'b1; exp_pc = '0; mctr = '0;
    m_cyc = 0; sh = '0; m_waddr = '0; fcnt = '0; cyc = 0;
  endtask

  // One clock cycle: drive inputs, play the memory, check against the model, advance.
  task automatic tick(input logic r, input logic [15:0] rpc);
    int p, ph;
    logic [15:0] w, mw, efc;
    logic ev, eoe;
    bit nb, np;
    sq.i_sq_redir = r;
    sq.i_sq_redir_pc = rpc;
    p = m_cyc;
    if (!sq.o_sq_cs_n && p >= 10) begin
      w  = m_waddr + 16'((p - 10) / 4);
      ph = (p - 10) % 4;
      mw = mem[w];
      sq.i_sq_sio = mw[ph*4 +: 4];
    end else begin
      sq.i_sq_sio = 4'($urandom);
    end
    #1;
    s_cs_n = sq.o_sq_cs_n; s_oe = sq.o_sq_sio_oe; s_sio = sq.o_sq_sio;
    s_vld = sq.o_sq_enc_vld; s_ctr = sq.o_sq_ctr; s_enc = sq.o_sq_enc;
    s_pc = sq.o_sq_pc; s_fcnt = sq.o_sq_fetch_cnt;

    tests++;
    if (s_ctr !== mctr) begin fails++; $display("FAIL ctr cyc=%0d got=%0d exp=%0d", cyc, s_ctr, mctr); end
    tests++;
    if (s_cs_n !== !m_busy) begin fails++; $display("FAIL cs_n cyc=%0d got=%0b exp=%0b", cyc, s_cs_n, !m_busy); end
    ev = 1'b0; eoe = 1'b0;
    if (!s_cs_n) begin
      eoe = (p < 8);
      if (p < 8) sh = {sh[27:0], s_sio};
      if (p == 7) begin
        last_addr = sh[23:0];
        m_waddr = sh[16:1];
        tests++;
        if (sh !== {8'h03, 7'b0, exp_pc, 1'b0}) begin
          fails++; $display("FAIL cmd_addr cyc=%0d got=%08h exp=%08h", cyc, sh, {8'h03, 7'b0, exp_pc, 1'b0});
        end
      end
      ev = (p >= 10) && (((p - 10) % 4) == 3) && !r;
    end
    tests++;
    if (s_oe !== eoe) begin fails++; $display("FAIL oe cyc=%0d got=%0b exp=%0b", cyc, s_oe, eoe); end
    if (s_cs_n || p >= 8) begin
      tests++;
      if (s_sio !== 4'h0) begin fails++; $display("FAIL sio_idle cyc=%0d got=%0h exp=0", cyc, s_sio); end
    end
    tests++;
    if (s_vld !== ev) begin fails++; $display("FAIL vld cyc=%0d got=%0b exp=%0b", cyc, s_vld, ev); end
    if (ev) begin
      tests++;
      if (s_enc !== mem[exp_pc] || s_pc !== exp_pc) begin
        fails++; $display("FAIL enc cyc=%0d got=%04h@%04h exp=%04h@%04h", cyc, s_enc, s_pc, mem[exp_pc], exp_pc);
      end
    end
`ifdef IDLI_SQI_FETCH_CNT_EN
    efc = fcnt;
`else
    efc = '0;
`endif
    tests++;
    if (s_fcnt !== efc) begin fails++; $display("FAIL fetch_cnt cyc=%0d got=%0d exp=%0d", cyc, s_fcnt, efc); end

    nb = m_busy; np = m_pend;
    if (ev) begin
      if (exp_pc == 16'hFFFF) begin nb = 1'b0; np = 1'b1; end
      exp_pc = exp_pc + 16'd1;
      fcnt = fcnt + 16'd1;
    end
    if (!m_busy && m_pend && mctr == 2'd1) begin nb = 1'b1; np = 1'b0; end
    if (r) begin nb = 1'b0; np = 1'b1; exp_pc = rpc; end
    m_busy = nb; m_pend = np;
    if (!s_cs_n) m_cyc++; else m_cyc = 0;
    mctr = mctr + 2'd1;
    cyc++;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sq.i_sq_redir = 1'b0; sq.i_sq_redir_pc = '0; sq.i_sq_sio = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    logic [3:0] seq [8];
    seq = '{4'h0, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    rst_n = 1'b0;
    sq.i_sq_redir = 1'b0; sq.i_sq_redir_pc = '0; sq.i_sq_sio = '0;
    #2;
    tests++;
    if ({sq.o_sq_cs_n, sq.o_sq_sio_oe, sq.o_sq_sio, sq.o_sq_enc_vld, sq.o_sq_ctr} !== {1'b1, 1'b0, 4'h0, 1'b0, 2'd0}) begin
      fails++; $display("FAIL reset_outs got=%b exp=%b",
        {sq.o_sq_cs_n, sq.o_sq_sio_oe, sq.o_sq_sio, sq.o_sq_enc_vld, sq.o_sq_ctr}, {1'b1, 1'b0, 4'h0, 1'b0, 2'd0});
    end
    tests++;
    if (sq.o_sq_fetch_cnt !== 16'd0 || sq.o_sq_pc !== 16'd0) begin
      fails++; $display("FAIL reset_cnt_pc got=%0h/%0h exp=0/0", sq.o_sq_fetch_cnt, sq.o_sq_pc);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 17; c++) begin
      tick(1'b0, 16'h0);
      if (c == 1) begin tests++; if (s_cs_n !== 1'b1) begin fails++; $display("FAIL cs_pre cyc=1 got=%0b exp=1", s_cs_n); end end
      if (c == 2) begin tests++; if (s_cs_n !== 1'b0) begin fails++; $display("FAIL cs_start cyc=2 got=%0b exp=0", s_cs_n); end end
      if (c >= 2 && c <= 9) begin
        tests++;
        if (s_sio !== seq[c-2]) begin fails++; $display("FAIL sio_seq cyc=%0d got=%0h exp=%0h", c, s_sio, seq[c-2]); end
      end
      if (c == 15) begin
        tests++;
        if (s_vld !== 1'b1 || s_enc !== 16'h1234) begin fails++; $display("FAIL first_vld cyc=15 got=%0b/%04h exp=1/1234", s_vld, s_enc); end
      end
      if (c == 16) begin
        tests++;
        if (s_pc !== 16'd1) begin fails++; $display("FAIL pc_after cyc=16 got=%0h exp=1", s_pc); end
      end
    end
  endtask

  task automatic test_redirect_data();
    int n, entry;
    logic [23:0] nibs;
    for (n = 0; n < 200 && !(m_busy && m_cyc >= 10 && mctr == 2'd3); n++) tick(1'b0, 16'h0);
    if (n >= 200) begin tests++; fails++; $display("FAIL redir_data_wait timeout got=%0d exp<200", n); end
    tick(1'b1, 16'h4321);
    tests++;
    if (s_vld !== 1'b0) begin fails++; $display("FAIL redir_vld_suppr got=%0b exp=0", s_vld); end
    tick(1'b0, 16'h0);
    tests++;
    if (s_cs_n !== 1'b1) begin fails++; $display("FAIL redir_cs_rise got=%0b exp=1", s_cs_n); end
    for (n = 0; n < 20; n++) begin tick(1'b0, 16'h0); if (!s_cs_n) break; end
    entry = cyc - 1;
    tick(1'b0, 16'h0);
    nibs = '0;
    for (int i = 0; i < 6; i++) begin tick(1'b0, 16'h0); nibs = {nibs[19:0], s_sio}; end
    tests++;
    if (nibs !== 24'h008642) begin fails++; $display("FAIL redir_addr got=%06h exp=008642", nibs); end
    for (n = 0; n < 20; n++) begin tick(1'b0, 16'h0); if (s_vld) break; end
    tests++;
    if (cyc - 1 - entry !== 13) begin fails++; $display("FAIL redir_latency got=%0d exp=13", cyc - 1 - entry); end
  endtask

  task automatic test_redir_addr();
    int n;
    tick(1'b1, 16'h0100);
    for (n = 0; n < 20 && !(m_busy && m_cyc == 4); n++) tick(1'b0, 16'h0);
    if (n >= 20) begin tests++; fails++; $display("FAIL addr_wait timeout got=%0d exp<20", n); end
    tick(1'b1, 16'h1111);
    tick(1'b1, 16'h2222);
    tests++;
    if (s_cs_n !== 1'b1) begin fails++; $display("FAIL abort_cs got=%0b exp=1", s_cs_n); end
    tick(1'b1, 16'hBEEF);
    for (n = 0; n < 40; n++) begin tick(1'b0, 16'h0); if (s_vld) break; end
    tests++;
    if (s_vld !== 1'b1 || s_pc !== 16'hBEEF || last_addr !== 24'h017DDE) begin
      fails++; $display("FAIL last_redir got=%0b/%04h/%06h exp=1/beef/017dde", s_vld, s_pc, last_addr);
    end
  endtask

  task automatic test_wrap();
    int n;
    tick(1'b1, 16'hFFFE);
    for (n = 0; n < 60; n++) begin tick(1'b0, 16'h0); if (s_vld && s_pc == 16'hFFFF) break; end
    tests++;
    if (n >= 60) begin fails++; $display("FAIL wrap_wait timeout got=%0d exp<60", n); end
    tick(1'b0, 16'h0);
    tests++;
    if (s_cs_n !== 1'b1 || s_pc !== 16'h0) begin fails++; $display("FAIL wrap_idle got=%0b/%04h exp=1/0000", s_cs_n, s_pc); end
    for (n = 0; n < 30; n++) begin tick(1'b0, 16'h0); if (s_vld) break; end
    tests++;
    if (s_vld !== 1'b1 || s_pc !== 16'h0 || last_addr !== 24'h0 || s_enc !== 16'h1234) begin
      fails++; $display("FAIL wrap_reread got=%0b/%04h/%06h/%04h exp=1/0000/000000/1234", s_vld, s_pc, last_addr, s_enc);
    end
  endtask

  task automatic test_async_reset();
    int n;
    bit early;
    tick(1'b1, 16'($urandom));
    for (n = 0; n < 30 && !(m_busy && m_cyc == 5); n++) tick(1'b0, 16'h0);
    if (n >= 30) begin tests++; fails++; $display("FAIL ares_wait timeout got=%0d exp<30", n); end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({sq.o_sq_cs_n, sq.o_sq_sio_oe, sq.o_sq_ctr} !== {1'b1, 1'b0, 2'd0}) begin
      fails++; $display("FAIL ares_immediate got=%b exp=%b", {sq.o_sq_cs_n, sq.o_sq_sio_oe, sq.o_sq_ctr}, {1'b1, 1'b0, 2'd0});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    early = 1'b0;
    for (int c = 0; c < 16; c++) begin
      tick(1'b0, 16'h0);
      if (c < 15 && s_vld) early = 1'b1;
    end
    tests++;
    if (early || s_vld !== 1'b1 || s_enc !== 16'h1234) begin
      fails++; $display("FAIL ares_first_vld got=early%0b/%0b/%04h exp=early0/1/1234", early, s_vld, s_enc);
    end
  endtask

  task automatic test_count();
    int n, got;
    logic [15:0] efc;
`ifdef IDLI_SQI_FETCH_CNT_EN
    efc = 16'd10;
`else
    efc = 16'd0;
`endif
    do_reset();
    got = 0;
    for (n = 0; n < 120 && got < 10; n++) begin tick(1'b0, 16'h0); if (s_vld) got++; end
    if (got < 10) begin tests++; fails++; $display("FAIL count_wait got=%0d exp=10", got); end
    tick(1'b1, 16'($urandom));
    for (int i = 0; i < 12; i++) begin
      tests++;
      if (s_fcnt !== efc) begin fails++; $display("FAIL count_hold i=%0d got=%0d exp=%0d", i, s_fcnt, efc); end
      tick(1'b0, 16'h0);
    end
  endtask

  task automatic test_random();
    int nv;
    logic r;
    logic [15:0] rpc;
    nv = 0;
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 39) == 0);
      rpc = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(16'hFFF0, 16'hFFFF)) : 16'($urandom);
      tick(r, rpc);
      if (s_vld) nv++;
    end
    tests++;
    if (nv < 50) begin fails++; $display("FAIL random_activity got=%0d exp>=50", nv); end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h1234;
    test_reset();
    test_redirect_data();
    test_redir_addr();
    test_wrap();
    test_async_reset();
    test_count();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
